// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    // Default divisor width and the divisor every channel loads at reset.
    localparam int DIV_W_DFLT       = 8;
    localparam int DEFAULT_DIV_DFLT = 2;

    // Smallest divisor that still yields a toggling output.
    localparam int MIN_DIV          = 2;

    typedef logic [DIV_W_DFLT-1:0] div_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter 0..D-1 with active/pending divisor and out/tick decode.
// Latency: outputs are combinational from the registered counter; writes take effect at the next wrap.
// Backpressure: pend_o stays high while a divisor waits, so the bank refuses further writes to this channel.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DFLT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             div_out_o,
    output logic             div_tick_o,
    output logic             pend_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             wrap;
    logic             apply;
    logic [DIV_W-1:0] half;

    // Next-state: sync and disable park the counter at 0; both, like a normal
    // wrap, are period boundaries where a waiting divisor can safely swap in.
    always_comb begin
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        apply      = 1'b0;
        wrap       = (cnt_q == act_q - DIV_W'(1));

        if (sync_i || !en_i) begin
            cnt_d = '0;
            apply = 1'b1;
        end else if (wrap) begin
            cnt_d = '0;
            apply = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        if (apply && pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
        end

        // The bank only strobes wr_i when the slot is free, so this never
        // collides with the apply above.
        if (wr_i && !pend_vld_q) begin
            pend_d     = wr_div_i;
            pend_vld_d = 1'b1;
        end
    end

    // State register; reset wins over everything, including a same-cycle write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q      <= '0;
            act_q      <= DIV_W'(DEFAULT_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Output decode: high for cnt in 1..floor(D/2), tick on the rising edge.
    always_comb begin
        half       = act_q >> 1;
        div_out_o  = en_i && (cnt_q != '0) && (cnt_q <= half);
        div_tick_o = en_i && (cnt_q == DIV_W'(1));
        pend_o     = pend_vld_q;
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers with a shared divisor-write port and global phase sync.
// Latency: accepted divisor lands in the channel's pending slot next edge, active at the next wrap; cfg_err one cycle after the handshake.
// Backpressure: cfg_ready drops while the addressed channel already holds a pending divisor.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DIV_W       = DIV_W_DFLT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [NCH-1:0]                      en,
    input  logic                                sync,
    input  logic                                cfg_valid,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                    cfg_div,
    output logic                                cfg_ready,
    output logic                                cfg_err,
    output logic [NCH-1:0]                      div_out,
    output logic [NCH-1:0]                      div_tick
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] pend_vld;
    logic [NCH-1:0] wr_stb;
    logic           cfg_hs;
    logic           ch_ok;
    logic           div_ok;
    logic           cfg_err_q, cfg_err_d;

    // Write decode: an out-of-range channel has no slot to fill, so it is
    // always ready and any handshake on it becomes an error.
    always_comb begin
        ch_ok     = ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));
        div_ok    = (cfg_div >= DIV_W'(MIN_DIV));
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_vld[i];
            end
        end
        cfg_hs    = cfg_valid & cfg_ready;
        for (int i = 0; i < NCH; i++) begin
            wr_stb[i] = cfg_hs & ch_ok & div_ok & (cfg_ch == CH_W'(i));
        end
        cfg_err_d = cfg_hs & ~(ch_ok & div_ok);
    end

    // Error flag: a one-cycle pulse following each discarded write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk        (clk),
            .resetn     (resetn),
            .en_i       (en[g]),
            .sync_i     (sync),
            .wr_i       (wr_stb[g]),
            .wr_div_i   (cfg_div),
            .div_out_o  (div_out[g]),
            .div_tick_o (div_tick[g]),
            .pend_o     (pend_vld[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: period-level reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_div_bank;

    localparam int NCH = 3;
    localparam int DIV_W = 8;
    localparam int DEF = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [NCH-1:0]   en = '0;
    logic             sync = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic [NCH-1:0]   div_out;
    logic [NCH-1:0]   div_tick;

    always #5 clk = ~clk;

    clk_div_bank #(.NCH(NCH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .div_tick  (div_tick)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: each channel is described by the cycle its current
    // period began, its divisor and an optional queued divisor (0 = none).
    int  cyc = 0;
    int  m_start[NCH];
    int  m_d[NCH];
    int  m_pend[NCH];
    bit  m_err = 1'b0;
    bit  chk_on = 1'b0;
    bit  rec_on = 1'b0;
    int  tq[$];

    function automatic bit m_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return m_pend[cfg_ch] == 0;
    endfunction

    function automatic int m_pos(input int i);
        return cyc - m_start[i];
    endfunction

    function automatic bit m_out(input int i);
        int p;
        p = m_pos(i);
        return en[i] && p >= 1 && p <= m_d[i] / 2;
    endfunction

    function automatic bit m_tick(input int i);
        return en[i] && m_pos(i) == 1;
    endfunction

    always @(posedge clk) begin : model
        bit rdy;
        bit hs;
        bit legal;
        int ch;
        int old;
        rdy   = m_ready();
        hs    = cfg_valid && rdy;
        ch    = int'(cfg_ch);
        legal = (ch < NCH) && (cfg_div >= 2);
        cyc++;
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                m_start[i] = cyc;
                m_d[i]     = DEF;
                m_pend[i]  = 0;
            end
            m_err = 1'b0;
        end else begin
            m_err = hs && !legal;
            for (int i = 0; i < NCH; i++) begin
                old = cyc - 1 - m_start[i];
                if (sync || !en[i] || old == m_d[i] - 1) begin
                    m_start[i] = cyc;
                    if (m_pend[i] != 0) begin
                        m_d[i]    = m_pend[i];
                        m_pend[i] = 0;
                    end
                end
            end
            if (hs && legal) m_pend[ch] = int'(cfg_div);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : compare
        logic [NCH-1:0] eo;
        logic [NCH-1:0] et;
        if (chk_on) begin
            for (int i = 0; i < NCH; i++) begin
                eo[i] = m_out(i);
                et[i] = m_tick(i);
            end
            check($sformatf("cyc%0d div_out", cyc), 32'(div_out), 32'(eo));
            check($sformatf("cyc%0d div_tick", cyc), 32'(div_tick), 32'(et));
            check($sformatf("cyc%0d cfg_ready", cyc), 32'(cfg_ready), 32'(m_ready()));
            check($sformatf("cyc%0d cfg_err", cyc), 32'(cfg_err), 32'(m_err));
        end
    end

    always @(negedge clk) begin
        if (rec_on && div_tick[2]) tq.push_back(cyc);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : main
        int exp32[10];
        int w;
        int n;
        exp32 = '{0, 1, 0, 1, 1, 1, 0, 0, 0, 1};

        // Reset state.
        tk(2);
        chk_on = 1'b1;
        check("rst_div_out", 32'(div_out), 0);
        check("rst_div_tick", 32'(div_tick), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_cfg_err", 32'(cfg_err), 0);

        // Release with all channels enabled at D=2.
        resetn = 1'b1;
        en = '1;
        #1;
        check("r031_out0_c0", 32'(div_out[0]), 0);
        for (int k = 1; k <= 4; k++) begin
            tk(1);
            check($sformatf("r031_out0_c%0d", k), 32'(div_out[0]), 32'(k % 2));
            check($sformatf("r031_tick0_c%0d", k), 32'(div_tick[0]), 32'(k % 2));
            check($sformatf("r031_mdl_c%0d", k), 32'(m_out(0)), 32'(k % 2));
        end

        // Change ch1 to D=6 mid-period of D=2.
        tk(1);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd6;
        #1;
        check("r032_ready_before", 32'(cfg_ready), 1);
        tk(1);
        cfg_valid = 1'b0;
        #1;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) tk(1);
            check($sformatf("r032_out1_%0d", j), 32'(div_out[1]), 32'(exp32[j]));
            check($sformatf("r032_mdl1_%0d", j), 32'(m_out(1)), 32'(exp32[j]));
            if (j == 1) check("r032_ready_apply", 32'(cfg_ready), 0);
            if (j == 2) check("r032_ready_after", 32'(cfg_ready), 1);
        end

        // Back-to-back writes on ch2: second stalls until the first is applied.
        sync = 1'b1;
        tk(1);
        sync = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd5;
        tk(1);
        cfg_div = 8'd7;
        rec_on = 1'b1;
        #1;
        check("r033_stall", 32'(cfg_ready), 0);
        w = 0;
        while (!cfg_ready && w < 20) begin
            tk(1);
            w++;
        end
        check("r033_wait_cycles", 32'(w), 1);
        tk(1);
        cfg_valid = 1'b0;
        tk(13);
        rec_on = 1'b0;
        check("r033_tick_count", 32'(tq.size()), 4);
        if (tq.size() >= 4) begin
            check("r033_period_old", 32'(tq[1] - tq[0]), 2);
            check("r033_period_5", 32'(tq[2] - tq[1]), 5);
            check("r033_period_7", 32'(tq[3] - tq[2]), 7);
        end

        // Illegal writes: divisor below 2, channel out of range.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
        #1;
        check("r034_ready_div1", 32'(cfg_ready), 1);
        tk(1);
        cfg_valid = 1'b0;
        #1;
        check("r034_err_div1", 32'(cfg_err), 1);
        check("r034_nopend_ch0", 32'(cfg_ready), 1);
        tk(1);
        check("r034_err_clear1", 32'(cfg_err), 0);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd4;
        #1;
        check("r034_ready_ch3", 32'(cfg_ready), 1);
        tk(1);
        cfg_valid = 1'b0;
        check("r034_err_ch3", 32'(cfg_err), 1);
        tk(1);
        check("r034_err_clear2", 32'(cfg_err), 0);

        // ch0 D=3, ch1 D=4, then sync realigns everything.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        tk(1);
        cfg_ch = 2'd1; cfg_div = 8'd4;
        tk(1);
        cfg_valid = 1'b0;
        tk(12);
        sync = 1'b1;
        tk(1);
        sync = 1'b0;
        #1;
        check("r035_tick_zero", 32'(div_tick), 0);
        check("r035_out_zero", 32'(div_out), 0);
        tk(1);
        check("r035_tick_all", 32'(div_tick), 7);
        check("r035_out_all", 32'(div_out), 7);
        tk(3);
        check("r035_tick_d3", 32'(div_tick), 1);

        // Disabled channel: outputs forced low, pending applies next cycle.
        en[0] = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        #1;
        check("r018_out_off", 32'(div_out[0]), 0);
        check("r018_tick_off", 32'(div_tick[0]), 0);
        tk(1);
        cfg_valid = 1'b0;
        #1;
        check("r023_pending", 32'(cfg_ready), 0);
        tk(1);
        check("r023_applied", 32'(cfg_ready), 1);
        en[0] = 1'b1;
        #1;
        check("r018_out_en_cycle", 32'(div_out[0]), 0);
        tk(1);
        check("r018_tick_first", 32'(div_tick[0]), 1);
        tk(4);
        check("r018_tick_d4", 32'(div_tick[0]), 1);

        // Largest divisor wraps cleanly.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd255;
        tk(1);
        cfg_valid = 1'b0;
        n = 0;
        while (!div_tick[2] && n < 600) begin
            tk(1);
            n++;
        end
        check("r026_first_tick", 32'(div_tick[2]), 1);
        tk(1);
        n = 0;
        while (!div_tick[2] && n < 600) begin
            tk(1);
            n++;
        end
        check("r026_period", 32'(n + 1), 255);

        // Reset mid-period with a pending write, plus a write during reset.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9;
        tk(1);
        cfg_valid = 1'b0;
        #1;
        check("r036_pending", 32'(cfg_ready), 0);
        resetn = 1'b0; sync = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        tk(1);
        check("r036_out", 32'(div_out), 0);
        check("r036_tick", 32'(div_tick), 0);
        check("r036_err", 32'(cfg_err), 0);
        resetn = 1'b1; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd1;
        #1;
        check("r036_pend_gone", 32'(cfg_ready), 1);
        for (int k = 1; k <= 4; k++) begin
            tk(1);
            check($sformatf("r036_default_c%0d", k), 32'(div_out), (k % 2) ? 32'd7 : 32'd0);
        end

        tk(2);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8: divisor width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset (2..2^DIV_W-1).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 en  input  NCH  per-channel enable.
REQ-007 sync  input  1  one-cycle pulse; phase-aligns all channels.
REQ-008 cfg_valid  input  1  divisor write request.
REQ-009 cfg_ch  input  $clog2(NCH) (min 1)  target channel.
REQ-010 cfg_div  input  DIV_W  requested divisor D.
REQ-011 cfg_ready  output  1  write accepted when cfg_valid & cfg_ready.
REQ-012 cfg_err  output  1  one-cycle pulse on an illegal write.
REQ-013 div_out  output  NCH  divided clock per channel.
REQ-014 div_tick  output  NCH  one-cycle pulse per channel, once per output period.

Function
REQ-015 Each channel SHALL hold a counter cnt (DIV_W bits) running 0..D-1, then wrapping to 0; D is the channel's active divisor.
REQ-016 div_out[i] SHALL equal (cnt>=1 && cnt<=floor(D/2)), combinational from registered cnt: D=2 high 1 of 2, D=6 high 3 of 6, D=5 high 2 of 5.
REQ-017 div_tick[i] SHALL be high exactly in cycles where cnt==1 and en[i]=1 (coincides with the div_out rising edge).
REQ-018 en[i]=0 SHALL hold cnt at 0, forcing div_out[i]=0 and div_tick[i]=0; after en[i] rises, cnt SHALL be 1 on the following cycle.
REQ-019 cfg_ready SHALL be 1 iff channel cfg_ch has no pending divisor; it SHALL stay 0 in the cycle that pending divisor is applied.
REQ-020 cfg_ch>=NCH, or cfg_div<2, on a handshake SHALL be discarded: no state change, cfg_err=1 on the next cycle.
REQ-021 An accepted legal write SHALL store cfg_div as the channel's pending divisor.
REQ-022 Pending divisor SHALL become active in the cycle cnt wraps D-1 -> 0, giving glitch-free output, with no truncated or stretched period; the pending slot then clears.
REQ-023 A disabled channel SHALL apply its pending divisor on the next cycle.
REQ-024 sync=1 SHALL force cnt=0 in every channel on the next edge and SHALL apply all pending divisors in the same edge; sync SHALL take priority over normal counting.
REQ-025 Writing the same divisor as the active one SHALL be legal and SHALL occupy the pending slot until the next wrap.
REQ-026 Counter arithmetic SHALL be DIV_W wide; D=2^DIV_W-1 SHALL wrap correctly without overflow.

Reset
REQ-027 On resetn=0: every cnt=0, active D=DEFAULT_DIV, pending slots empty, cfg_err=0; therefore div_out=0, div_tick=0, cfg_ready=1.
REQ-028 Reset SHALL override sync, cfg writes and en; a write in the reset cycle SHALL be lost.

Structure
REQ-029 Package clk_div_pkg SHALL hold DIV_W default, DEFAULT_DIV, MIN_DIV=2 and a typedef for the divisor.
REQ-030 One sub-module, clk_div_chan (counter, active/pending divisor, out/tick decode), SHALL be instantiated NCH times; the top contains only cfg decode, error flag and sync fan-out.

Verification
REQ-031 Reset release, en=all 1, D=2: div_out[0] = 0,1,0,1...; div_tick[0] pulses every 2 cycles starting 2nd cycle.
REQ-032 Write ch1 D=6 mid-period of D=2: current D=2 period completes, then div_out[1] is high 3 / low 3; no runt pulse.
REQ-033 Write ch2 D=5, then write ch2 D=7 before wrap: second write stalls (cfg_ready=0) until wrap, then accepted; periods seen: 2 (old), 5, 7.
REQ-034 cfg_div=1 or cfg_ch=NCH: cfg_err pulses once, no channel changes, cfg_ready stays 1.
REQ-035 Channels at D=3 and D=4 out of phase, assert sync: both cnt=0 next cycle, both div_tick pulse together one cycle later.
REQ-036 Assert resetn=0 mid-period with a pending write: all outputs 0 next cycle, D returns to DEFAULT_DIV, pending discarded.
